// File: rtl/screen_offset_ctrl.sv
// -----------------------------------------------------------------------------
// screen_offset_ctrl
//   Push-button front end for the adjustable-position VGA core. Raw keys are
//   synchronised and debounced, then key[0] toggles between horizontal and
//   vertical adjust and key[1]/key[2] step the selected offset down/up with
//   saturation. Requested offsets are committed to the outputs only on
//   frame_start, so the picture never shifts mid-frame.
//
//   Optional feature macro: SCREEN_AUTOREPEAT_EN
//     When defined, holding key[1] or key[2] auto-repeats the step after
//     REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   synchronous reset, active-low
//   key[2:0]     in   raw keys, active-low: [0] mode, [1] left/up, [2] right/down
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   mode         out  0 = horizontal adjust, 1 = vertical adjust
//   h_offset     out  committed signed horizontal offset (+ = right)
//   v_offset     out  committed signed vertical offset (+ = down)
//   pending      out  a requested offset is not yet committed
// -----------------------------------------------------------------------------
module screen_offset_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int OFF_W           = 8,
  parameter int H_MAX           = 64,
  parameter int V_MAX           = 48,
  parameter int STEP            = 1,
  parameter int REPEAT_DELAY    = 12_500_000,
  parameter int REPEAT_PERIOD   = 2_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              key,
  input  logic                    frame_start,
  output logic                    mode,
  output logic signed [OFF_W-1:0] h_offset,
  output logic signed [OFF_W-1:0] v_offset,
  output logic                    pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic signed [OFF_W:0] H_LIM  = (OFF_W+1)'(H_MAX);
  localparam logic signed [OFF_W:0] V_LIM  = (OFF_W+1)'(V_MAX);
  localparam logic signed [OFF_W:0] STEP_W = (OFF_W+1)'(STEP);

  // Input conditioning: sync chain, debounced level (1 = released), press pulse
  logic [2:0]    sync1, sync2;
  logic [2:0]    db;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic rpt_up, rpt_dn;

`ifdef SCREEN_AUTOREPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic          held_up, held_dn;
  logic          rpt_armed;
  logic [RW-1:0] rpt_cnt;

  // Exactly one of the step keys held; both held suppresses repeats.
  assign held_up = ~db[2] &  db[1];
  assign held_dn = ~db[1] &  db[2];

  // Counter starts on the cycle the key is seen pressed (same cycle as the
  // press pulse is registered), so the first repeat lands REPEAT_DELAY after
  // the press step and later ones every REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (!rst_n || !(held_up || held_dn) || press[0]) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_up    <= 1'b0;
      rpt_dn    <= 1'b0;
    end else begin
      rpt_up  <= 1'b0;
      rpt_dn  <= 1'b0;
      rpt_cnt <= rpt_cnt + 1'b1;
      if (!rpt_armed && rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
        rpt_armed <= 1'b1;
        rpt_cnt   <= '0;
        rpt_up    <= held_up;
        rpt_dn    <= held_dn;
      end else if (rpt_armed && rpt_cnt == RW'(REPEAT_PERIOD - 1)) begin
        rpt_cnt <= '0;
        rpt_up  <= held_up;
        rpt_dn  <= held_dn;
      end
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // Step direction; opposing requests in the same cycle cancel.
  logic step_up, step_dn;
  always_comb begin
    step_up = press[2] | rpt_up;
    step_dn = press[1] | rpt_dn;
    if (step_up && step_dn) begin
      step_up = 1'b0;
      step_dn = 1'b0;
    end
  end

  // Widened by one bit so the add/subtract cannot wrap before clamping.
  function automatic logic signed [OFF_W-1:0] step_sat(
    input logic signed [OFF_W-1:0] cur,
    input logic                    up,
    input logic                    dn,
    input logic signed [OFF_W:0]   lim
  );
    logic signed [OFF_W:0] w;
    w = {cur[OFF_W-1], cur};
    if (up)      w = w + STEP_W;
    else if (dn) w = w - STEP_W;
    if (w > lim)       w = lim;
    else if (w < -lim) w = -lim;
    return w[OFF_W-1:0];
  endfunction

  logic signed [OFF_W-1:0] req_h, req_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode     <= 1'b0;
      req_h    <= '0;
      req_v    <= '0;
      h_offset <= '0;
      v_offset <= '0;
      pending  <= 1'b0;
    end else begin
      if (press[0]) mode <= ~mode;
      // Step uses the mode before any toggle in this same cycle.
      if (!mode) req_h <= step_sat(req_h, step_up, step_dn, H_LIM);
      else       req_v <= step_sat(req_v, step_up, step_dn, V_LIM);
      // Commit takes the pre-step request; a coincident step waits a frame.
      if (frame_start) begin
        h_offset <= req_h;
        v_offset <= req_v;
      end
      pending <= (req_h != h_offset) || (req_v != v_offset);
    end
  end

endmodule

// File: tb/tb_screen_offset_ctrl.sv
module tb_screen_offset_ctrl;

  localparam int DB    = 4;
  localparam int OFF_W = 8;
  localparam int HM    = 3;
  localparam int VM    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [2:0]              key;
  logic                    frame_start;
  logic                    mode;
  logic signed [OFF_W-1:0] h_offset, v_offset;
  logic                    pending;

  screen_offset_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .OFF_W(OFF_W),
    .H_MAX(HM),
    .V_MAX(VM),
    .STEP(1),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .frame_start(frame_start),
    .mode(mode),
    .h_offset(h_offset),
    .v_offset(v_offset),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model at event level: requested and committed offsets.
  int  m_mode, m_req_h, m_req_v, m_h, m_v;
  bit  chk_en = 1'b0;

  function automatic int clamp(input int x, input int lim);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_req_h = 0; m_req_v = 0; m_h = 0; m_v = 0;
  endfunction

  function automatic void m_step(input int d);
    if (m_mode == 0) m_req_h = clamp(m_req_h + d, HM);
    else             m_req_v = clamp(m_req_v + d, VM);
  endfunction

  function automatic void m_commit();
    m_h = m_req_h;
    m_v = m_req_v;
  endfunction

  function automatic int m_pending();
    return ((m_req_h != m_h) || (m_req_v != m_v)) ? 1 : 0;
  endfunction

  // Continuous comparison whenever the design is settled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mode",     int'(mode),               m_mode);
      check("h_offset", int'($signed(h_offset)),  m_h);
      check("v_offset", int'($signed(v_offset)),  m_v);
      check("pending",  int'(pending),            m_pending());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold keys in mask pressed long enough to debounce, then release.
  task automatic press_keys(input logic [2:0] mask, input int hold);
    chk_en = 1'b0;
    key = ~mask;
    cyc(hold);
    key = '1;
    cyc(DB + 6);
  endtask

  task automatic frame();
    chk_en = 1'b0;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    cyc(3);
    m_commit();
    chk_en = 1'b1;
  endtask

  task automatic settle();
    chk_en = 1'b1;
    cyc(3);
  endtask

  initial begin
    rst_n = 1'b0;
    key = '1;
    frame_start = 1'b0;
    m_reset();

    // 1: reset with keys toggling
    @(posedge clk); #1 key = 3'b010;
    @(posedge clk); #1 key = 3'b101;
    @(negedge clk);
    check("rst_mode",    int'(mode), 0);
    check("rst_h",       int'($signed(h_offset)), 0);
    check("rst_v",       int'($signed(v_offset)), 0);
    check("rst_pending", int'(pending), 0);
    #1 key = '1;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(12);

    // 2: bouncing key[2] gives one step
    chk_en = 1'b0;
    key = 3'b011; cyc(2);
    key = 3'b111; cyc(1);
    key = 3'b011; cyc(10);
    key = 3'b111; cyc(DB + 6);
    m_step(1);
    settle();
    @(negedge clk);
    check("lit_pending_bounce", int'(pending), 1);
    check("lit_h_before_commit", int'($signed(h_offset)), 0);
    #1 frame();
    @(negedge clk);
    check("lit_h_bounce", int'($signed(h_offset)), 1);
    check("lit_pending_clear", int'(pending), 0);

    // 3: saturation at -H_MAX
    for (int i = 0; i < 5; i++) begin
      press_keys(3'b010, DB + 6);
      m_step(-1);
      settle();
    end
    frame();
    cyc(2);
    check("lit_h_sat", int'($signed(h_offset)), -3);
    press_keys(3'b010, DB + 6);
    m_step(-1);
    settle();
    check("lit_pending_sat", int'(pending), 0);

    // 4: mode routing to vertical
    press_keys(3'b001, DB + 6);
    m_mode = 1;
    settle();
    for (int i = 0; i < 3; i++) begin
      press_keys(3'b100, DB + 6);
      m_step(1);
      settle();
    end
    frame();
    cyc(2);
    check("lit_v_sat", int'($signed(v_offset)), 2);
    check("lit_h_kept", int'($signed(h_offset)), -3);

    // 5a: both step keys pressed together cancel
    press_keys(3'b110, DB + 6);
    settle();

    // 5b: step landing together with frame_start defers the commit
    chk_en = 1'b0;
    key = 3'b101;
    cyc(6);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    cyc(DB + 6 - 7);
    key = '1;
    cyc(DB + 6);
    m_commit();
    m_step(-1);
    settle();
    check("lit_v_deferred", int'($signed(v_offset)), 2);
    check("lit_pending_deferred", int'(pending), 1);
    frame();
    cyc(2);
    check("lit_v_committed", int'($signed(v_offset)), 1);

    // 6: long hold of key[2] in horizontal mode
    press_keys(3'b001, DB + 6);
    m_mode = 0;
    settle();
    press_keys(3'b100, DB + 3 + 60);
`ifdef SCREEN_AUTOREPEAT_EN
    for (int i = 0; i < 6; i++) m_step(1);
`else
    m_step(1);
`endif
    settle();
    frame();
    cyc(2);
`ifdef SCREEN_AUTOREPEAT_EN
    check("lit_h_hold", int'($signed(h_offset)), 3);
`else
    check("lit_h_hold", int'($signed(h_offset)), -2);
`endif

    // Reset mid-operation discards an uncommitted request
    press_keys(3'b100, DB + 6);
    m_step(1);
    settle();
    chk_en = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    m_reset();
    settle();
    frame();
    cyc(4);
    check("lit_h_after_reset", int'($signed(h_offset)), 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
